timer_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one down-counting delay timer among N requesters. It replaces the per-FSM START/RDY timer handshake: a requester raises its request with a delay value, holds it, and receives a one-cycle completion pulse when its delay expires. Only one requester owns the timer at a time. The block sits between the Moore control FSMs in the timers task and a single shared counter resource.

---
 rtl/timer_arbiter.sv | 122 ++++++++++++
 tb/tb_timer_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Round-robin arbiter that hands one shared down-counting delay timer to N requesters.
// A granted requester holds req until its one-cycle done pulse, or drops it to abandon.
module timer_arbiter #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] dly,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   done,
   output logic           busy,
   output logic [W-1:0]   count
);

   localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [N-1:0]   done_q, done_d;
   logic           busy_q, busy_d;
   logic [W-1:0]   count_q, count_d;
   logic [PtrW-1:0] ptr_q, ptr_d;

   logic            found;
   logic [PtrW-1:0] pick;
   logic [PtrW-1:0] cand;

   // Rotating priority scan: first asserted request at or after ptr, wrapping mod N.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int unsigned off = 0; off < N; off++) begin
         cand = PtrW'((32'(ptr_q) + off) % N);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Next-state and registered-output logic for the IDLE/COUNT/DONE sequencer.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      busy_d  = busy_q;
      count_d = count_q;
      ptr_d   = ptr_q;
      case (state_q)
         StIdle: begin
            if (found) begin
               state_d = StCount;
               gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick;
               busy_d  = 1'b1;
               count_d = dly[32'(pick)*W +: W];
               // Pointer moves at grant so an abandoning requester still yields priority.
               ptr_d   = (pick == PtrW'(N-1)) ? '0 : pick + PtrW'(1);
            end else begin
               gnt_d   = '0;
               busy_d  = 1'b0;
               count_d = '0;
            end
         end
         StCount: begin
            // Abandon beats expiry.
            if ((req & gnt_q) == '0) begin
               state_d = StIdle;
               gnt_d   = '0;
               busy_d  = 1'b0;
               count_d = '0;
            end else if (count_q == '0) begin
               state_d = StDone;
               done_d  = gnt_q;
            end else begin
               count_d = count_q - W'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
            gnt_d   = '0;
            busy_d  = 1'b0;
            count_d = '0;
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
            busy_d  = 1'b0;
            count_d = '0;
         end
      endcase
   end

   // State and output registers; async active-low reset clears everything including ptr.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         count_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         count_q <= count_d;
         ptr_q   <= ptr_d;
      end
   end

   assign gnt   = gnt_q;
   assign done  = done_q;
   assign busy  = busy_q;
   assign count = count_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter (N=4, W=8); outputs sampled 1 time unit after posedge.
module tb_timer_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] dly;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        busy;
   logic [7:0]  count;

   int total = 0;
   int bad   = 0;

   timer_arbiter #(.N(4), .W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .dly   (dly),
      .gnt   (gnt),
      .done  (done),
      .busy  (busy),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req   = '0;
      dly   = '0;
      #3;
      total++;
      if ({gnt, done, busy, count} !== 17'd0) begin
         bad++;
         $display("FAIL reset: got gnt=%b done=%b busy=%b count=%0d want all zero",
                  gnt, done, busy, count);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   // req=0001, D=3: count 3,2,1,0 after edges 1-4, done after 5, idle after 6.
   task automatic test_single();
      logic [3:0] eg[6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
      logic [3:0] ed[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
      logic       eb[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [7:0] ec[6] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
      dly[0 +: 8] = 8'd3;
      req = 4'b0001;
      for (int e = 0; e < 6; e++) begin
         step();
         total++;
         if ({gnt, done, busy, count} !== {eg[e], ed[e], eb[e], ec[e]}) begin
            bad++;
            $display("FAIL single edge%0d: got gnt=%b done=%b busy=%b count=%0d want %b %b %b %0d",
                     e + 1, gnt, done, busy, count, eg[e], ed[e], eb[e], ec[e]);
         end
         if (e == 4) req = 4'b0000;
      end
   endtask

   // req=0100, D=0: gnt after edge 1, done after edge 2, idle after edge 3 (ptr -> 3).
   task automatic test_zero_delay();
      logic [3:0] eg[3] = '{4'b0100, 4'b0100, 4'b0000};
      logic [3:0] ed[3] = '{4'b0000, 4'b0100, 4'b0000};
      logic       eb[3] = '{1'b1, 1'b1, 1'b0};
      dly[16 +: 8] = 8'd0;
      req = 4'b0100;
      for (int e = 0; e < 3; e++) begin
         step();
         total++;
         if ({gnt, done, busy, count} !== {eg[e], ed[e], eb[e], 8'd0}) begin
            bad++;
            $display("FAIL zero_delay edge%0d: got gnt=%b done=%b busy=%b count=%0d want %b %b %b 0",
                     e + 1, gnt, done, busy, count, eg[e], ed[e], eb[e]);
         end
         if (e == 1) req = 4'b0000;
      end
   endtask

   // ptr=3, req=1001, D=1 each: requester 3 first, then requester 0 after one idle cycle.
   task automatic test_rotation();
      logic [3:0] eg[8] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000,
                            4'b0001, 4'b0001, 4'b0001, 4'b0000};
      logic [3:0] ed[8] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000,
                            4'b0000, 4'b0000, 4'b0001, 4'b0000};
      logic [7:0] ec[8] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0};
      dly[24 +: 8] = 8'd1;
      dly[0 +: 8]  = 8'd1;
      req = 4'b1001;
      for (int e = 0; e < 8; e++) begin
         step();
         total++;
         if ({gnt, done, count} !== {eg[e], ed[e], ec[e]}) begin
            bad++;
            $display("FAIL rotation edge%0d: got gnt=%b done=%b count=%0d want %b %b %0d",
                     e + 1, gnt, done, count, eg[e], ed[e], ec[e]);
         end
         if (e == 2) req = 4'b0001;
         if (e == 6) req = 4'b0000;
      end
   endtask

   // ptr=1, req=0010 D=10; drop at count=6 while raising req[0] (D=2).
   task automatic test_abandon();
      logic [3:0] eg[7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
      logic [7:0] ec[7] = '{8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd0, 8'd2};
      logic       eb[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      dly[8 +: 8] = 8'd10;
      dly[0 +: 8] = 8'd2;
      req = 4'b0010;
      for (int e = 0; e < 7; e++) begin
         step();
         total++;
         if ({gnt, done, busy, count} !== {eg[e], 4'b0000, eb[e], ec[e]}) begin
            bad++;
            $display("FAIL abandon edge%0d: got gnt=%b done=%b busy=%b count=%0d want %b 0000 %b %0d",
                     e + 1, gnt, done, busy, count, eg[e], eb[e], ec[e]);
         end
         if (e == 4) req = 4'b0001;
      end
      // Let requester 0 finish: count 1, 0, then done, then idle.
      step();
      step();
      step();
      total++;
      if (done !== 4'b0001) begin
         bad++;
         $display("FAIL abandon_followup_done: got done=%b want 0001", done);
      end
      req = 4'b0000;
      step();
   endtask

   // From ptr=0, req=1111, D=1: order 0,1,2,3, 3 owned cycles + 1 idle each.
   task automatic test_contention();
      logic [3:0] oh;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) dly[i*8 +: 8] = 8'd1;
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         oh = 4'b0001 << i;
         for (int e = 0; e < 4; e++) begin
            step();
            total++;
            if (e < 3 && gnt !== oh) begin
               bad++;
               $display("FAIL contention grant%0d edge%0d: got gnt=%b want %b", i, e, gnt, oh);
            end else if (e == 3 && gnt !== 4'b0000) begin
               bad++;
               $display("FAIL contention idle%0d: got gnt=%b want 0000", i, gnt);
            end
            total++;
            if (done !== ((e == 2) ? oh : 4'b0000)) begin
               bad++;
               $display("FAIL contention done%0d edge%0d: got done=%b want %b",
                        i, e, done, (e == 2) ? oh : 4'b0000);
            end
            if (e == 2) req = req & ~oh;
         end
      end
   endtask

   // Reset at count=4 clears outputs without an edge; then ptr=0 picks 0 over 1.
   task automatic test_async_reset();
      dly[0 +: 8] = 8'd8;
      dly[8 +: 8] = 8'd5;
      req = 4'b0001;
      for (int e = 0; e < 5; e++) step();
      total++;
      if (count !== 8'd4) begin
         bad++;
         $display("FAIL async_pre: got count=%0d want 4", count);
      end
      #2;
      reset = 1'b0;
      #1;
      total++;
      if ({gnt, done, busy, count} !== 17'd0) begin
         bad++;
         $display("FAIL async_reset: got gnt=%b done=%b busy=%b count=%0d want all zero",
                  gnt, done, busy, count);
      end
      @(negedge clk);
      req   = 4'b0011;
      reset = 1'b1;
      step();
      total++;
      if ({gnt, busy, count} !== {4'b0001, 1'b1, 8'd8}) begin
         bad++;
         $display("FAIL async_regrant: got gnt=%b busy=%b count=%0d want 0001 1 8",
                  gnt, busy, count);
      end
      req = 4'b0000;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero_delay();
      test_rotation();
      test_abandon();
      test_contention();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
